bsg_arb_rr_burst_lock: RTL and testbench
========================================

// Module: bsg_arb_rr_burst_lock
// PURPOSE
//  Shares one downstream valid/ready channel between inputs_p requesters with
//  round-robin priority.
//  A grant locks to the winner for a multi-beat burst, ended by last_i or by
//  the max_burst_p fairness cap. After the burst the grant passes round-robin.
//  Sits in front of a shared resource (network link, memory port), in the
//  same role as the locking fixed-priority arbiters, but with fair rotation.
// PARAMETERS
//  inputs_p     16  number of requesters (>=2)
//  max_burst_p  8   max beats per lock before forced release (>=1; 1 = never lock)
//  lg_inputs_lp     derived: $clog2(inputs_p)
//  lg_burst_lp      derived: $clog2(max_burst_p+1)
// PORTS
//  clk_i          in   1            clock, all state on posedge
//  reset_n_i      in   1            asynchronous, active-low reset
//  v_i            in   inputs_p     per-requester valid
//  last_i         in   inputs_p     per-requester last-beat-of-burst flag, qualified by v_i
//  yumi_o         out  inputs_p     one-hot beat accept back to the requester
//  v_o            out  1            downstream valid
//  last_o         out  1            downstream last, = last_i[sel_id_o]
//  ready_i        in   1            downstream ready
//  sel_id_o       out  lg_inputs_lp index of the current selection (for the data mux)
//  sel_one_hot_o  out  inputs_p     one-hot current selection; 0 when nothing is selected
//  locked_o       out  1            1 while in the LOCKED state
// BEHAVIOUR
//  State: st_r {IDLE, LOCKED}, ptr_r [lg_inputs_lp], owner_r [lg_inputs_lp], cnt_r [lg_burst_lp].
//  Reset (reset_n_i=0, async):
//   - st_r=IDLE, ptr_r=0, owner_r=0, cnt_r=0.
//   - v_o, yumi_o, sel_one_hot_o, locked_o forced to 0 while reset is asserted.
//   - A burst in flight is abandoned with no release beat.
//  IDLE:
//   - Winner = first set v_i at or above ptr_r, wrapping from inputs_p-1 to 0.
//   - Selection is combinational, zero-cycle latency.
//   - sel_one_hot_o = one-hot winner; v_o = |v_i.
//   - sel_id_o = winner index, or ptr_r when no v_i is set.
//  LOCKED:
//   - Selection = owner_r only; v_o = v_i[owner_r].
//   - Other requesters are never accepted, even when the owner deasserts v_i (no bubble skip).
//  Handshake:
//   - xfer = v_o & ready_i. yumi_o = sel_one_hot_o & {inputs_p{xfer}}.
//   - v_o never depends on ready_i; at most one yumi_o bit is set.
//  Transitions, on xfer only; no xfer means state holds:
//   - IDLE, xfer, ~last_o, max_burst_p>1 -> LOCKED. owner_r<=winner, cnt_r<=1, ptr_r unchanged.
//   - IDLE, xfer, last_o or max_burst_p==1 -> IDLE. ptr_r<=winner+1 mod inputs_p.
//   - LOCKED, xfer, last_o -> IDLE. ptr_r<=owner_r+1 mod inputs_p, cnt_r<=0.
//   - LOCKED, xfer, ~last_o, cnt_r==max_burst_p-1 -> IDLE (forced release).
//     ptr_r<=owner_r+1, cnt_r<=0. The owner re-arbitrates for the rest of its burst.
//   - LOCKED, xfer otherwise -> cnt_r<=cnt_r+1.
//  Boundaries:
//   - The pointer wraps: winner 15 with inputs_p=16 gives ptr_r=0.
//   - cnt_r never exceeds max_burst_p-1.
//   - last_i of unselected requesters is ignored.
//   - A 1-beat burst (v & last) never enters LOCKED.
// TESTING
//  1. Reset: hold reset_n_i=0 with v_i=16'hFFFF.
//     -> v_o=0, yumi_o=0, locked_o=0. After release: sel_id_o=0, yumi_o=16'h0001 when ready_i=1.
//  2. RR rotation: v_i=16'h8421, last_i=16'hFFFF, ready_i=1 for 5 cycles.
//     -> grants 0,5,10,15,0. Pointer wraps 15->0.
//  3. Lock: req 3 sends a 4-beat burst, last on beat 4, with v_i=16'hFFFF.
//     -> yumi_o=16'h0008 for 4 xfers. locked_o=1 after beat 1. Next grant goes to req 4.
//  4. Forced release: max_burst_p=8, req 2 sends a 10-beat burst, req 6 valid.
//     -> 8 beats to req 2, then req 6's burst, then req 2 resumes with its remaining beats.
//  5. Backpressure and gap in LOCKED: ready_i=0 for 3 cycles, then the owner drops v_i 2 cycles.
//     -> yumi_o=0 throughout, cnt_r holds, the lock is not lost, no other requester is granted.
//  6. Reset mid-lock: assert reset_n_i at beat 2 of a burst from req 9.
//     -> locked_o=0 immediately (async). After release, arbitration restarts from ptr 0.

Source files
------------

// File: rtl/bsg_arb_rr_burst_lock.sv
// Round-robin arbiter that locks the grant to one requester for a multi-beat burst.
// Latency: zero cycles; selection and yumi are combinational from v_i/ready_i and state.
// Backpressure: ready_i low stalls the winner in place; state advances only on v_o & ready_i.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   v_i, last_i             per-requester valid and last-beat flag
//   yumi_o                  one-hot beat accept back to the requester
//   v_o, last_o, ready_i    downstream channel
//   sel_id_o, sel_one_hot_o current selection (index / one-hot) for the data mux
//   locked_o                high while a burst holds the grant
module bsg_arb_rr_burst_lock #(
  parameter  int inputs_p     = 16,
  parameter  int max_burst_p  = 8,
  localparam int lg_inputs_lp = $clog2(inputs_p),
  localparam int lg_burst_lp  = $clog2(max_burst_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [inputs_p-1:0]     v_i,
  input  logic [inputs_p-1:0]     last_i,
  output logic [inputs_p-1:0]     yumi_o,
  output logic                    v_o,
  output logic                    last_o,
  input  logic                    ready_i,
  output logic [lg_inputs_lp-1:0] sel_id_o,
  output logic [inputs_p-1:0]     sel_one_hot_o,
  output logic                    locked_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} st_e;

  localparam logic [lg_burst_lp-1:0] cnt_max_lp = lg_burst_lp'(max_burst_p - 1);

  st_e                     st_r, st_n;
  logic [lg_inputs_lp-1:0] ptr_r, ptr_n;
  logic [lg_inputs_lp-1:0] owner_r, owner_n;
  logic [lg_burst_lp-1:0]  cnt_r, cnt_n;

  logic [lg_inputs_lp-1:0] win, idx, sel_id;
  logic                    found, v_sel, xfer;
  logic [inputs_p-1:0]     sel_oh;

  function automatic logic [lg_inputs_lp-1:0] incr_wrap(input logic [lg_inputs_lp-1:0] x);
    if (int'(x) == inputs_p - 1) return '0;
    else                         return x + lg_inputs_lp'(1);
  endfunction

  // Rotating priority search: first valid at or above ptr_r, wrapping.
  always_comb begin
    found = 1'b0;
    win   = ptr_r;
    idx   = '0;
    for (int i = 0; i < inputs_p; i++) begin
      idx = lg_inputs_lp'((int'(ptr_r) + i) % inputs_p);
      if (!found && v_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // While locked only the owner is visible, even if it drops valid, so no
  // other requester can slip a beat into the middle of a burst.
  always_comb begin
    sel_id = ptr_r;
    sel_oh = '0;
    v_sel  = 1'b0;
    if (st_r == LOCKED) begin
      sel_id = owner_r;
      sel_oh = inputs_p'(1) << owner_r;
      v_sel  = v_i[owner_r];
    end else begin
      v_sel = |v_i;
      if (found) begin
        sel_id = win;
        sel_oh = inputs_p'(1) << win;
      end
    end
  end

  // Outputs are gated by reset so nothing is offered or accepted while it is held.
  assign v_o           = v_sel & reset_n_i;
  assign sel_one_hot_o = sel_oh & {inputs_p{reset_n_i}};
  assign xfer          = v_o & ready_i;
  assign yumi_o        = sel_one_hot_o & {inputs_p{xfer}};
  assign locked_o      = (st_r == LOCKED) & reset_n_i;
  assign sel_id_o      = sel_id;
  assign last_o        = last_i[sel_id];

  always_comb begin
    st_n    = st_r;
    ptr_n   = ptr_r;
    owner_n = owner_r;
    cnt_n   = cnt_r;
    if (xfer) begin
      if (st_r == IDLE) begin
        if (!last_o && (max_burst_p > 1)) begin
          st_n    = LOCKED;
          owner_n = sel_id;
          cnt_n   = lg_burst_lp'(1);
        end else begin
          ptr_n = incr_wrap(sel_id);
        end
      end else begin
        // Either a true last beat or the fairness cap releases the grant;
        // on the cap the owner simply re-arbitrates for the remainder.
        if (last_o || (cnt_r == cnt_max_lp)) begin
          st_n  = IDLE;
          ptr_n = incr_wrap(owner_r);
          cnt_n = '0;
        end else begin
          cnt_n = cnt_r + lg_burst_lp'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      st_r    <= IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      cnt_r   <= '0;
    end else begin
      st_r    <= st_n;
      ptr_r   <= ptr_n;
      owner_r <= owner_n;
      cnt_r   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_bsg_arb_rr_burst_lock.sv
// Directed bench for the round-robin burst-locking arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Expected grants are hand-derived for inputs_p=16, max_burst_p=8.
module tb_bsg_arb_rr_burst_lock;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [15:0] v_i, last_i, yumi_o, sel_one_hot_o;
  logic        v_o, last_o, ready_i, locked_o;
  logic [3:0]  sel_id_o;

  int n_chk  = 0;
  int n_pass = 0;

  bsg_arb_rr_burst_lock #(.inputs_p(16), .max_burst_p(8)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .v_i           (v_i),
    .last_i        (last_i),
    .yumi_o        (yumi_o),
    .v_o           (v_o),
    .last_o        (last_o),
    .ready_i       (ready_i),
    .sel_id_o      (sel_id_o),
    .sel_one_hot_o (sel_one_hot_o),
    .locked_o      (locked_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic [15:0] v, input logic [15:0] l, input logic r);
    @(posedge clk_i);
    #1;
    v_i = v; last_i = l; ready_i = r;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0; v_i = '0; last_i = '0; ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  // Forced-release table: req 2 bursts 10 beats, req 6 holds a single-beat request.
  logic [15:0] t4_v [0:10] = '{16'h0044, 16'h0044, 16'h0044, 16'h0044, 16'h0044, 16'h0044,
                               16'h0044, 16'h0044, 16'h0044, 16'h0004, 16'h0004};
  logic [15:0] t4_l [0:10] = '{16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040,
                               16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0004};
  logic [15:0] t4_y [0:10] = '{16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h0004,
                               16'h0004, 16'h0004, 16'h0040, 16'h0004, 16'h0004};
  logic        t4_k [0:10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int          rr_exp [0:4] = '{0, 5, 10, 15, 0};

  initial begin
    // 1. Reset with every requester valid.
    reset_n_i = 1'b0; v_i = 16'hFFFF; last_i = 16'hFFFF; ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_v_o",    32'(v_o),           32'h0);
    chk("rst_yumi",   32'(yumi_o),        32'h0);
    chk("rst_locked", 32'(locked_o),      32'h0);
    chk("rst_onehot", 32'(sel_one_hot_o), 32'h0);
    #2 reset_n_i = 1'b1;
    #1;
    chk("rel_sel_id", 32'(sel_id_o), 32'h0);
    chk("rel_yumi",   32'(yumi_o),   32'h0001);

    // 2. Round-robin rotation over 0,5,10,15 with pointer wrap.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(16'h8421, 16'hFFFF, 1'b1);
      chk($sformatf("rr_id%0d", k),   32'(sel_id_o), 32'(rr_exp[k]));
      chk($sformatf("rr_yumi%0d", k), 32'(yumi_o),   32'h1 << rr_exp[k]);
      chk($sformatf("rr_lk%0d", k),   32'(locked_o), 32'h0);
    end

    // 3. Lock: move pointer to 3, then req 3 sends 4 beats against full contention.
    do_reset();
    drive(16'h0004, 16'h0004, 1'b1);
    chk("lk_pre", 32'(yumi_o), 32'h0004);
    for (int k = 0; k < 4; k++) begin
      drive(16'hFFFF, (k == 3) ? 16'hFFFF : 16'hFFF7, 1'b1);
      chk($sformatf("lk_yumi%0d", k), 32'(yumi_o),   32'h0008);
      chk($sformatf("lk_lk%0d", k),   32'(locked_o), (k == 0) ? 32'h0 : 32'h1);
      chk($sformatf("lk_last%0d", k), 32'(last_o),   (k == 3) ? 32'h1 : 32'h0);
    end
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    chk("lk_next", 32'(yumi_o),   32'h0010);
    chk("lk_done", 32'(locked_o), 32'h0);

    // 4. Forced release after 8 beats, req 6 served, req 2 resumes.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      drive(t4_v[k], t4_l[k], 1'b1);
      chk($sformatf("fr_yumi%0d", k), 32'(yumi_o),   32'(t4_y[k]));
      chk($sformatf("fr_lk%0d", k),   32'(locked_o), 32'(t4_k[k]));
    end
    drive(16'h0000, 16'h0000, 1'b1);
    chk("fr_end_lk", 32'(locked_o), 32'h0);
    chk("fr_end_v",  32'(v_o),      32'h0);

    // 5. Backpressure then owner gap inside a lock held by req 1.
    do_reset();
    drive(16'h0002, 16'h0000, 1'b1);
    chk("bp_first", 32'(yumi_o), 32'h0002);
    for (int k = 0; k < 3; k++) begin
      drive(16'hFFFF, 16'h0000, 1'b0);
      chk($sformatf("bp_yumi%0d", k), 32'(yumi_o),    32'h0);
      chk($sformatf("bp_v%0d", k),    32'(v_o),       32'h1);
      chk($sformatf("bp_lk%0d", k),   32'(locked_o),  32'h1);
      chk($sformatf("bp_cnt%0d", k),  32'(dut.cnt_r), 32'h1);
    end
    for (int k = 0; k < 2; k++) begin
      drive(16'hFFFD, 16'h0000, 1'b1);
      chk($sformatf("gap_yumi%0d", k), 32'(yumi_o),    32'h0);
      chk($sformatf("gap_v%0d", k),    32'(v_o),       32'h0);
      chk($sformatf("gap_id%0d", k),   32'(sel_id_o),  32'h1);
      chk($sformatf("gap_lk%0d", k),   32'(locked_o),  32'h1);
      chk($sformatf("gap_cnt%0d", k),  32'(dut.cnt_r), 32'h1);
    end
    drive(16'hFFFF, 16'h0000, 1'b1);
    chk("bp_resume", 32'(yumi_o), 32'h0002);
    drive(16'h0002, 16'h0002, 1'b1);
    chk("bp_cnt2",  32'(dut.cnt_r), 32'h2);
    chk("bp_lastb", 32'(yumi_o),    32'h0002);
    drive(16'h0000, 16'h0000, 1'b1);
    chk("bp_unlk", 32'(locked_o), 32'h0);

    // 6. Reset in the middle of a burst from req 9.
    do_reset();
    drive(16'h0200, 16'h0000, 1'b1);
    chk("mr_b1", 32'(yumi_o), 32'h0200);
    drive(16'h0200, 16'h0000, 1'b1);
    chk("mr_b2_lk", 32'(locked_o), 32'h1);
    #1 reset_n_i = 1'b0;
    #1;
    chk("mr_lk_async", 32'(locked_o), 32'h0);
    chk("mr_v_async",  32'(v_o),      32'h0);
    chk("mr_yumi",     32'(yumi_o),   32'h0);
    repeat (2) @(negedge clk_i);
    v_i = 16'h0000; last_i = 16'h0000;
    reset_n_i = 1'b1;
    #1;
    chk("mr_ptr0", 32'(sel_id_o),      32'h0);
    chk("mr_oh0",  32'(sel_one_hot_o), 32'h0);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    chk("mr_grant0", 32'(yumi_o), 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
